// File: rtl/sprite_scheduler.sv
// Per-line sprite row fetch engine sharing one synchronous sprite ROM with a game read port.
// Define SPRITE_COLLISION_EN to build the per-frame dinosaur collision flag.
module sprite_scheduler #(
  parameter int unsigned NOBJ = 3,
  parameter int unsigned ID_W = 3
) (
  input  logic                 vga_clk,
  input  logic                 clrn,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 rdn,
  input  logic [8:0]           row_addr,
  input  logic [9:0]           col_addr,
  input  logic [NOBJ*10-1:0]   obj_x,
  input  logic [NOBJ*9-1:0]    obj_y,
  input  logic [NOBJ*ID_W-1:0] obj_id,
  input  logic [NOBJ-1:0]      obj_en,
  output logic [ID_W+4:0]      rom_addr,
  input  logic [31:0]          rom_data,
  input  logic                 gm_req,
  input  logic [ID_W+4:0]      gm_addr,
  output logic                 gm_ack,
  output logic [31:0]          gm_data,
  output logic [NOBJ-1:0]      px_obj,
  output logic                 busy,
  output logic                 collide
);

  localparam int unsigned K_W = (NOBJ > 1) ? $clog2(NOBJ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_GAME  = 3'd3;
  localparam logic [2:0] S_GACK  = 3'd4;

  logic [2:0]     state, state_nx;
  logic [K_W-1:0] k, k_nx;
  logic [K_W-1:0] issue_idx;
  logic           issue, pend_clr, gm_take, gm_done;
  logic           vs_d, hs_d, fetch_pend;
  logic [8:0]     row_lat, row_sel;
  logic [9:0]     dy_c;
  logic           hit_c;

  logic [9:0]      sh_x  [NOBJ];
  logic [8:0]      sh_y  [NOBJ];
  logic [ID_W-1:0] sh_id [NOBJ];
  logic            sh_en [NOBJ];
  logic [31:0]     lbuf  [NOBJ];
  logic [9:0]      dx_c  [NOBJ];

  logic           s1_vld, s1_hit, s2_vld, s2_hit;
  logic [K_W-1:0] s1_idx, s2_idx;

  // Frame-start attribute shadows and line-start fetch request
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      fetch_pend <= 1'b0;
      for (int i = 0; i < NOBJ; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        sh_id[i] <= '0;
        sh_en[i] <= 1'b0;
      end
    end else begin
      vs_d <= vs;
      hs_d <= hs;
      if (hs && !hs_d)  fetch_pend <= 1'b1;
      else if (pend_clr) fetch_pend <= 1'b0;
      if (vs && !vs_d) begin
        for (int i = 0; i < NOBJ; i++) begin
          sh_x[i]  <= obj_x[i*10 +: 10];
          sh_y[i]  <= obj_y[i*9 +: 9];
          sh_id[i] <= obj_id[i*ID_W +: ID_W];
          sh_en[i] <= obj_en[i];
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // k is the object index in FETCH and the cycle counter in DRAIN
  always_comb begin
    state_nx  = state;
    k_nx      = k;
    issue     = 1'b0;
    issue_idx = k;
    pend_clr  = 1'b0;
    gm_take   = 1'b0;
    gm_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_pend) begin
          state_nx  = S_FETCH;
          pend_clr  = 1'b1;
          issue     = 1'b1;
          issue_idx = '0;
          k_nx      = '0;
        end else if (gm_req) begin
          state_nx = S_GAME;
          gm_take  = 1'b1;
        end
      end
      S_FETCH: begin
        if (k == K_W'(NOBJ - 1)) begin
          state_nx = S_DRAIN;
          k_nx     = '0;
        end else begin
          issue     = 1'b1;
          issue_idx = k + K_W'(1);
          k_nx      = k + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (k == '0) begin
          k_nx = K_W'(1);
        end else begin
          state_nx = S_IDLE;
          k_nx     = '0;
        end
      end
      S_GAME:  state_nx = S_GACK;
      S_GACK: begin
        gm_done  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The first issue happens on FETCH entry, so it uses the live row before it is latched
  assign row_sel = (state == S_IDLE) ? row_addr : row_lat;
  assign dy_c    = 10'(row_sel) - 10'(sh_y[issue_idx]);
  assign hit_c   = sh_en[issue_idx] && (row_sel >= sh_y[issue_idx]) && (dy_c < 10'd32);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rom_addr <= '0;
      row_lat  <= '0;
      gm_ack   <= 1'b0;
      gm_data  <= '0;
      busy     <= 1'b0;
      s1_vld   <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s2_vld   <= 1'b0;
      s2_hit   <= 1'b0;
      s2_idx   <= '0;
      for (int i = 0; i < NOBJ; i++) lbuf[i] <= '0;
    end else begin
      gm_ack <= gm_done;
      busy   <= (state_nx == S_FETCH) || (state_nx == S_DRAIN);
      if (gm_done)  gm_data <= rom_data;
      if (pend_clr) row_lat <= row_addr;
      if (issue)        rom_addr <= {sh_id[issue_idx], dy_c[4:0]};
      else if (gm_take) rom_addr <= gm_addr;
      s1_vld <= issue;
      s1_hit <= hit_c;
      s1_idx <= issue_idx;
      s2_vld <= s1_vld;
      s2_hit <= s1_hit;
      s2_idx <= s1_idx;
      if (s2_vld) lbuf[s2_idx] <= s2_hit ? rom_data : 32'd0;
    end
  end

  always_comb begin
    px_obj = '0;
    for (int i = 0; i < NOBJ; i++) begin
      dx_c[i]   = col_addr - sh_x[i];
      px_obj[i] = !rdn && (col_addr >= sh_x[i]) && (dx_c[i] < 10'd32) && lbuf[i][~dx_c[i][4:0]];
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic hit;

  // Sticky overlap of the dinosaur with any other object, published once per frame
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      hit     <= 1'b0;
      collide <= 1'b0;
    end else if (vs && !vs_d) begin
      collide <= hit;
      hit     <= 1'b0;
    end else if (px_obj[0] && (|px_obj[NOBJ-1:1])) begin
      hit <= 1'b1;
    end
  end
`else
  assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomized self-checking bench for sprite_scheduler against a line/pixel reference model.
module tb_sprite_scheduler;

  localparam int NOBJ = 3;
  localparam int ID_W = 3;
  localparam int AW   = ID_W + 5;
  localparam int XW   = NOBJ * 10;
  localparam int YW   = NOBJ * 9;
  localparam int IW   = NOBJ * ID_W;

  logic            vga_clk = 1'b0;
  logic            clrn, hs, vs, rdn;
  logic [8:0]      row_addr;
  logic [9:0]      col_addr;
  logic [XW-1:0]   obj_x;
  logic [YW-1:0]   obj_y;
  logic [IW-1:0]   obj_id;
  logic [NOBJ-1:0] obj_en;
  logic [AW-1:0]   rom_addr;
  logic [31:0]     rom_data = '0;
  logic            gm_req;
  logic [AW-1:0]   gm_addr;
  logic            gm_ack;
  logic [31:0]     gm_data;
  logic [NOBJ-1:0] px_obj;
  logic            busy, collide;

  int n_chk = 0;
  int n_pass = 0;
  bit rom_const = 1'b0;

  int ax [NOBJ] = '{default: 0};
  int ay [NOBJ] = '{default: 0};
  int aid[NOBJ] = '{default: 0};
  bit aen[NOBJ] = '{default: 0};
  int mx [NOBJ] = '{default: 0};
  int my [NOBJ] = '{default: 0};
  int mid[NOBJ] = '{default: 0};
  bit men[NOBJ] = '{default: 0};
  logic [31:0] lw[NOBJ] = '{default: 0};
  bit m_hit = 1'b0;
  bit m_col = 1'b0;

  sprite_scheduler #(.NOBJ(NOBJ), .ID_W(ID_W)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs), .rdn(rdn),
    .row_addr(row_addr), .col_addr(col_addr),
    .obj_x(obj_x), .obj_y(obj_y), .obj_id(obj_id), .obj_en(obj_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .gm_req(gm_req), .gm_addr(gm_addr), .gm_ack(gm_ack), .gm_data(gm_data),
    .px_obj(px_obj), .busy(busy), .collide(collide)
  );

  always #20 vga_clk = ~vga_clk;

  function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    if (rom_const) return 32'h8000_0001;
    return (x * 32'h9E37_79B1) ^ (x << 17) ^ 32'hC3A5_1E0F;
  endfunction

  // Synchronous sprite ROM: data valid the cycle after the address is sampled
  always @(posedge vga_clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [NOBJ-1:0] exp_px(input int c, input int r);
    logic [NOBJ-1:0] p;
    p = '0;
    if (c < 640 && r < 480)
      for (int i = 0; i < NOBJ; i++)
        if (c >= mx[i] && c - mx[i] < 32) p[i] = lw[i][31 - (c - mx[i])];
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NOBJ; i++) begin
      obj_x[i*10 +: 10]     = 10'(ax[i]);
      obj_y[i*9 +: 9]       = 9'(ay[i]);
      obj_id[i*ID_W +: ID_W] = ID_W'(aid[i]);
      obj_en[i]             = aen[i];
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NOBJ; i++) begin
      mx[i] = 0; my[i] = 0; mid[i] = 0; men[i] = 0; lw[i] = '0;
    end
    m_hit = 0;
    m_col = 0;
  endtask

  task automatic do_vs();
    logic exp_c;
    @(negedge vga_clk);
    rdn = 1'b1;
    vs  = 1'b1;
    @(negedge vga_clk);
    vs = 1'b0;
    for (int i = 0; i < NOBJ; i++) begin
      mx[i] = ax[i]; my[i] = ay[i]; mid[i] = aid[i]; men[i] = aen[i];
    end
    m_col = m_hit;
    m_hit = 0;
`ifdef SPRITE_COLLISION_EN
    exp_c = m_col;
`else
    exp_c = 1'b0;
`endif
    check("collide", 32'(collide), 32'(exp_c));
  endtask

  task automatic do_fetch(input int r, input bit with_game, input logic [AW-1:0] gaddr);
    int busy_n, acks;
    bit seen, done, ack_early;
    logic [AW-1:0] exp_addr;
    @(negedge vga_clk);
    row_addr = 9'(r);
    col_addr = '0;
    rdn      = 1'b1;
    hs       = 1'b1;
    for (int i = 0; i < NOBJ; i++)
      lw[i] = (men[i] && r >= my[i] && r - my[i] < 32) ?
              rom_fn({ID_W'(mid[i]), 5'(r - my[i])}) : 32'd0;
    exp_addr = {ID_W'(mid[0]), 5'(r - my[0])};
    busy_n = 0; acks = 0; seen = 0; done = 0; ack_early = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge vga_clk);
      if (cyc == 0) begin
        hs = 1'b0;
        if (with_game) begin gm_req = 1'b1; gm_addr = gaddr; end
      end
      if (busy) begin
        if (!seen) check("fetch_first_addr", 32'(rom_addr), 32'(exp_addr));
        seen = 1;
        busy_n++;
      end
      if (gm_ack) begin
        acks++;
        if (busy || !seen) ack_early = 1;
        check("arb_gm_data", gm_data, rom_fn(gaddr));
        gm_req = 1'b0;
      end
      done = seen && !busy && (!with_game || acks > 0);
    end
    check("fetch_done", 32'(done), 32'd1);
    check("busy_len", 32'(busy_n), 32'(NOBJ + 2));
    if (with_game) begin
      repeat (3) begin
        @(negedge vga_clk);
        if (gm_ack) acks++;
      end
      check("arb_ack_count", 32'(acks), 32'd1);
      check("arb_ack_after_busy", 32'(ack_early), 32'd0);
    end
  endtask

  task automatic do_sweep(input int r);
    logic [NOBJ-1:0] e;
    for (int c = 0; c < 660; c++) begin
      @(negedge vga_clk);
      col_addr = 10'(c);
      rdn      = !(c < 640 && r < 480);
      #1;
      e = exp_px(c, r);
      check($sformatf("px r%0d c%0d", r, c), 32'(px_obj), 32'(e));
      if (e[0] && (|e[NOBJ-1:1])) m_hit = 1;
    end
    @(negedge vga_clk);
    rdn = 1'b1;
  endtask

  task automatic do_line(input int r);
    do_fetch(r, 1'b0, '0);
    do_sweep(r);
  endtask

  task automatic do_game(input logic [AW-1:0] a);
    int lat;
    bit got;
    @(negedge vga_clk);
    gm_req = 1'b1; gm_addr = a; lat = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge vga_clk);
      lat++;
      got = gm_ack;
    end
    check("gm_ack_seen", 32'(got), 32'd1);
    check("gm_latency", 32'(lat), 32'd3);
    check("gm_data", gm_data, rom_fn(a));
    gm_req = 1'b0;
    @(negedge vga_clk);
    check("gm_ack_pulse", 32'(gm_ack), 32'd0);
    check("gm_data_hold", gm_data, rom_fn(a));
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int id, input bit en);
    ax[i] = x; ay[i] = y; aid[i] = id; aen[i] = en;
  endtask

  initial begin
    int tc[5] = '{100, 131, 99, 101, 132};
    int te[5] = '{1, 1, 0, 0, 0};
    clrn = 1'b0; hs = 1'b0; vs = 1'b0; rdn = 1'b1;
    row_addr = '0; col_addr = '0; gm_req = 1'b0; gm_addr = '0;
    obj_x = '0; obj_y = '0; obj_id = '0; obj_en = '0;

    // Reset held with random inputs
    repeat (6) begin
      @(negedge vga_clk);
      hs = 1'($urandom); vs = 1'($urandom); rdn = 1'($urandom);
      row_addr = 9'($urandom); col_addr = 10'($urandom);
      obj_x = XW'($urandom); obj_y = YW'($urandom); obj_id = IW'($urandom);
      obj_en = NOBJ'($urandom); gm_req = 1'($urandom); gm_addr = AW'($urandom);
      #1;
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_gm_ack", 32'(gm_ack), 32'd0);
      check("rst_gm_data", gm_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_collide", 32'(collide), 32'd0);
      check("rst_px", 32'(px_obj), 32'd0);
    end
    @(negedge vga_clk);
    hs = 1'b0; vs = 1'b0; gm_req = 1'b0; rdn = 1'b1;
    drive();
    clrn = 1'b1;
    do_line(10);

    // Single object with edge-pixel ROM pattern
    rom_const = 1'b1;
    set_obj(0, 100, 50, 2, 1'b1);
    drive();
    do_vs();
    do_fetch(50, 1'b0, '0);
    check("single_addr", 32'(rom_addr) & 32'h0, 32'h0);
    do_sweep(50);
    for (int j = 0; j < 5; j++) begin
      @(negedge vga_clk);
      col_addr = 10'(tc[j]);
      rdn = 1'b0;
      #1;
      check($sformatf("single_col%0d", tc[j]), 32'(px_obj[0]), 32'(te[j]));
    end
    @(negedge vga_clk);
    rdn = 1'b1;
    do_line(82);

    // Mid-frame attribute change waits for the next latch
    ax[0] = 300;
    drive();
    do_line(60);
    do_vs();
    do_line(60);

    // Game port alone, then racing a fetch
    do_game(AW'(8'h45));
    do_game(AW'(8'h9c));
    do_fetch(60, 1'b1, AW'(8'h45));
    do_sweep(60);

    // Screen edges and disabled object
    set_obj(0, 620, 470, 5, 1'b1);
    drive();
    do_vs();
    do_line(469);
    do_line(470);
    do_line(479);
    aen[0] = 1'b0;
    drive();
    do_vs();
    do_line(470);

    // Collision: overlap for one frame, then separated
    set_obj(0, 100, 50, 1, 1'b1);
    set_obj(1, 131, 50, 3, 1'b1);
    drive();
    do_vs();
    do_line(50);
    ax[1] = 300;
    drive();
    do_vs();
    do_line(50);
    do_vs();

    // Randomized frames with mid-frame attribute churn and game traffic
    rom_const = 1'b0;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NOBJ; i++)
        set_obj(i, $urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0);
      drive();
      do_vs();
      for (int i = 0; i < NOBJ; i++)
        set_obj(i, $urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 7), 1'b1);
      drive();
      for (int l = 0; l < 3; l++) begin
        int j, r;
        j = $urandom_range(0, NOBJ - 1);
        r = my[j] + $urandom_range(0, 40);
        if (r > 511) r = 511;
        do_fetch(r, $urandom_range(0, 2) == 0, AW'($urandom));
        do_sweep(r);
      end
      do_game(AW'($urandom));
    end
    do_vs();

    // Reset during a game access: no ack, data cleared
    @(negedge vga_clk);
    gm_req = 1'b1; gm_addr = AW'(8'h12);
    @(negedge vga_clk);
    clrn = 1'b0; gm_req = 1'b0;
    reset_model();
    repeat (3) begin
      @(negedge vga_clk);
      check("abort_gm_ack", 32'(gm_ack), 32'd0);
      check("abort_gm_data", gm_data, 32'd0);
    end
    @(negedge vga_clk);
    clrn = 1'b1;

    // Reset during a fetch: buffers and shadows cleared
    set_obj(0, 0, 0, 1, 1'b1);
    set_obj(1, 0, 0, 2, 1'b0);
    set_obj(2, 0, 0, 3, 1'b0);
    drive();
    do_vs();
    do_line(5);
    @(negedge vga_clk);
    row_addr = 9'd5; hs = 1'b1;
    @(negedge vga_clk);
    hs = 1'b0;
    repeat (2) @(negedge vga_clk);
    clrn = 1'b0;
    reset_model();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    check("abort_collide", 32'(collide), 32'd0);
    @(negedge vga_clk);
    clrn = 1'b1;
    do_sweep(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
